// File: rtl/rgb_stream_packer_if.sv
// rtl/rgb_stream_packer_if.sv - pixel-in / AXI4-Stream-out handshake bundle for rgb_stream_packer
interface rgb_stream_packer_if;
    logic [7:0]  in_r;
    logic [7:0]  in_g;
    logic [7:0]  in_b;
    logic        in_valid;
    logic        in_eol;
    logic        in_sof;
    logic        in_ready;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        out_tuser;

    modport master (
        output in_r, in_g, in_b, in_valid, in_eol, in_sof, out_tready,
        input  in_ready, out_tdata, out_tvalid, out_tlast, out_tuser
    );

    modport slave (
        input  in_r, in_g, in_b, in_valid, in_eol, in_sof, out_tready,
        output in_ready, out_tdata, out_tvalid, out_tlast, out_tuser
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// rtl/rgb_stream_packer.sv - packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words)
module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               aclk,
    input  logic               aresetn,
    rgb_stream_packer_if.slave bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]  state, state_nx;
    logic [23:0] acc, acc_nx;
    logic [1:0]  cnt, cnt_nx;
    logic        sof_pending, sof_pending_nx;
    logic [31:0] tdata;
    logic        tvalid, tlast, tuser;
    logic        out_free, accept, sof_any;
    logic        ld, ld_last, ld_user;
    logic [31:0] ld_data;
    logic [23:0] pix;
    logic [47:0] ext;

    function automatic logic [31:0] pad_word(input logic [23:0] bytes, input logic [1:0] n);
        logic [31:0] w;
        w = {8'h00, bytes};
        for (int i = 0; i < 4; i++)
            if (i >= int'(n)) w[8*i +: 8] = PAD_BYTE;
        return w;
    endfunction

    assign out_free     = !tvalid || bus.out_tready;
    assign bus.in_ready = aresetn && (state == RUN) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pix          = {bus.in_r, bus.in_g, bus.in_b};
    // Pending bytes sit in the low lanes; the new pixel lands right above them.
    assign ext          = {24'h0, acc} | ({24'h0, pix} << {cnt, 3'b000});

    always_comb begin
        state_nx       = state;
        acc_nx         = acc;
        cnt_nx         = cnt;
        sof_pending_nx = sof_pending;
        ld             = 1'b0;
        ld_data        = 32'h0;
        ld_last        = 1'b0;
        ld_user        = 1'b0;
        sof_any        = sof_pending || bus.in_sof;
        if (state == FLUSH) begin
            if (out_free) begin
                ld             = 1'b1;
                ld_data        = pad_word(acc, cnt);
                ld_last        = 1'b1;
                ld_user        = sof_pending;
                sof_pending_nx = 1'b0;
                acc_nx         = 24'h0;
                cnt_nx         = 2'd0;
                state_nx       = RUN;
            end
        end else if (accept) begin
            if (bus.in_sof && cnt != 2'd0) begin
                // Old-frame bytes leave alone; the SOF pixel starts a fresh accumulator.
                ld             = 1'b1;
                ld_data        = pad_word(acc, cnt);
                acc_nx         = pix;
                cnt_nx         = 2'd3;
                sof_pending_nx = 1'b1;
                if (bus.in_eol) state_nx = FLUSH;
            end else if (cnt == 2'd0) begin
                if (bus.in_eol) begin
                    ld             = 1'b1;
                    ld_data        = pad_word(pix, 2'd3);
                    ld_last        = 1'b1;
                    ld_user        = sof_any;
                    sof_pending_nx = 1'b0;
                end else begin
                    acc_nx         = pix;
                    cnt_nx         = 2'd3;
                    sof_pending_nx = sof_any;
                end
            end else begin
                ld             = 1'b1;
                ld_data        = ext[31:0];
                ld_user        = sof_any;
                sof_pending_nx = 1'b0;
                acc_nx         = {8'h00, ext[47:32]};
                cnt_nx         = cnt - 2'd1;
                if (bus.in_eol) begin
                    if (cnt == 2'd1) ld_last = 1'b1;
                    else             state_nx = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= RUN;
            acc         <= 24'h0;
            cnt         <= 2'd0;
            sof_pending <= 1'b0;
            tdata       <= 32'h0;
            tvalid      <= 1'b0;
            tlast       <= 1'b0;
            tuser       <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            cnt         <= cnt_nx;
            sof_pending <= sof_pending_nx;
            if (ld) begin
                tdata  <= ld_data;
                tlast  <= ld_last;
                tuser  <= ld_user;
                tvalid <= 1'b1;
            end else if (bus.out_tready) begin
                tvalid <= 1'b0;
            end
        end
    end

    assign bus.out_tdata  = tdata;
    assign bus.out_tvalid = tvalid;
    assign bus.out_tlast  = tlast;
    assign bus.out_tuser  = tuser;
endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb/tb_rgb_stream_packer.sv - self-checking bench for rgb_stream_packer
module tb_rgb_stream_packer;
    localparam logic [7:0] PAD = 8'h00;

    typedef struct { logic [7:0] r, g, b; logic eol, sof; } px_t;
    typedef struct { logic [31:0] data; logic last, user; } word_t;

    logic aclk = 1'b0;
    logic aresetn;
    rgb_stream_packer_if bus();

    rgb_stream_packer #(.PAD_BYTE(PAD)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    px_t        tx_q[$];
    word_t      exp_q[$];
    word_t      got_q[$];
    logic [7:0] seg[$];
    logic       seg_sof;
    int         tests = 0;
    int         fails = 0;
    int         vprob = 100;
    int         rprob = 100;
    logic       hold_prev;
    logic [31:0] prev_data;
    logic       prev_last, prev_user;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a frame/line is a byte segment cut into 4-byte words, last one padded.
    task automatic close_seg(input logic last);
        bit first = 1;
        while (seg.size() > 0) begin
            word_t w;
            int n;
            w.data = {4{PAD}};
            n = (seg.size() < 4) ? seg.size() : 4;
            for (int i = 0; i < n; i++) w.data[8*i +: 8] = seg.pop_front();
            w.user = seg_sof && first;
            w.last = last && (seg.size() == 0);
            exp_q.push_back(w);
            first = 0;
        end
        seg_sof = 0;
    endtask

    task automatic model_accept(input px_t p);
        if (p.sof && seg.size() > 0) close_seg(1'b0);
        if (p.sof) seg_sof = 1;
        seg.push_back(p.b);
        seg.push_back(p.g);
        seg.push_back(p.r);
        if (p.eol) close_seg(1'b1);
    endtask

    task automatic add_px(input logic [7:0] r, g, b, input logic eol, sof);
        px_t p;
        p.r = r; p.g = g; p.b = b; p.eol = eol; p.sof = sof;
        tx_q.push_back(p);
    endtask

    task automatic add_line(input int n, input logic sof);
        for (int i = 0; i < n; i++)
            add_px(8'($urandom), 8'($urandom), 8'($urandom), i == n - 1, sof && i == 0);
    endtask

    task automatic tick();
        @(negedge aclk);
        if (tx_q.size() > 0 && $urandom_range(99) < vprob) begin
            bus.in_valid = 1'b1;
            bus.in_r     = tx_q[0].r;
            bus.in_g     = tx_q[0].g;
            bus.in_b     = tx_q[0].b;
            bus.in_eol   = tx_q[0].eol;
            bus.in_sof   = tx_q[0].sof;
        end else begin
            bus.in_valid = 1'b0;
            bus.in_eol   = 1'b0;
            bus.in_sof   = 1'b0;
        end
        bus.out_tready = ($urandom_range(99) < rprob);
        #1;
        if (hold_prev) begin
            check("hold_tvalid", bus.out_tvalid, 1);
            check("hold_tdata", bus.out_tdata, prev_data);
            check("hold_tlast", bus.out_tlast, prev_last);
            check("hold_tuser", bus.out_tuser, prev_user);
        end
        if (bus.out_tvalid && !bus.out_tready) check("hold_in_ready", bus.in_ready, 0);
        if (bus.in_valid && bus.in_ready) model_accept(tx_q.pop_front());
        if (bus.out_tvalid && bus.out_tready) begin
            word_t w;
            w.data = bus.out_tdata;
            w.last = bus.out_tlast;
            w.user = bus.out_tuser;
            got_q.push_back(w);
        end
        hold_prev = bus.out_tvalid && !bus.out_tready;
        prev_data = bus.out_tdata;
        prev_last = bus.out_tlast;
        prev_user = bus.out_tuser;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (tx_q.size() > 0 && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, tx_q.size(), 0);
        rprob = 100;
        repeat (4) tick();
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
            check($sformatf("%s_user%0d", tag, i), got_q[i].user, exp_q[i].user);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlast, nuser;
        aresetn        = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_r       = 8'hAA;
        bus.in_g       = 8'hBB;
        bus.in_b       = 8'hCC;
        bus.in_eol     = 1'b1;
        bus.in_sof     = 1'b1;
        bus.out_tready = 1'b1;
        hold_prev      = 1'b0;
        seg_sof        = 1'b0;

        // Reset held with a pixel offered
        repeat (3) begin
            @(negedge aclk);
            #1;
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_tvalid", bus.out_tvalid, 0);
            check("rst_tdata", bus.out_tdata, 0);
            check("rst_tlast", bus.out_tlast, 0);
            check("rst_tuser", bus.out_tuser, 0);
        end
        @(negedge aclk);
        aresetn      = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("ready_after_release", bus.in_ready, 1);
        repeat (3) tick();
        check("rst_no_word", got_q.size(), 0);

        // Single packing group
        add_px(8'h11, 8'h12, 8'h13, 0, 0);
        add_px(8'h21, 8'h22, 8'h23, 0, 0);
        add_px(8'h31, 8'h32, 8'h33, 0, 0);
        add_px(8'h41, 8'h42, 8'h43, 1, 0);
        drain("group");
        check("group_n", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("group_w0", got_q[0].data, 32'h23111213);
            check("group_w1", got_q[1].data, 32'h32332122);
            check("group_w2", got_q[2].data, 32'h41424331);
            check("group_l1", got_q[1].last, 0);
            check("group_l2", got_q[2].last, 1);
        end
        compare("group");

        // Latency: word from a lone EOL pixel is valid the next cycle
        add_px(8'h01, 8'h02, 8'h03, 1, 0);
        tick();
        check("lat_accepted", tx_q.size(), 0);
        tick();
        check("lat_tvalid", bus.out_tvalid, 1);
        check("lat_tdata", bus.out_tdata, {PAD, 24'h010203});
        drain("lat");
        compare("lat");

        // 6-pixel line: flush word plus one ready-low cycle
        for (int i = 1; i <= 6; i++)
            add_px(8'(16 * i + 1), 8'(16 * i + 2), 8'(16 * i + 3), i == 6, 0);
        for (int n = 0; n < 50 && tx_q.size() > 0; n++) tick();
        tick();
        check("six_flush_ready0", bus.in_ready, 0);
        tick();
        check("six_flush_ready1", bus.in_ready, 1);
        drain("six");
        check("six_n", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check("six_w4", got_q[4].data, {PAD, PAD, 8'h61, 8'h62});
            check("six_l4", got_q[4].last, 1);
            check("six_l3", got_q[3].last, 0);
        end
        compare("six");

        // SOF on first pixel of a line
        add_line(8, 1);
        drain("sof0");
        nuser = 0;
        foreach (got_q[i]) nuser += int'(got_q[i].user);
        check("sof0_users", nuser, 1);
        if (got_q.size() > 0) check("sof0_first_user", got_q[0].user, 1);
        compare("sof0");

        // SOF arriving with one byte pending
        add_px(8'hA1, 8'hA2, 8'hA3, 0, 0);
        add_px(8'hB1, 8'hB2, 8'hB3, 0, 0);
        add_px(8'hC1, 8'hC2, 8'hC3, 0, 0);
        add_px(8'hD1, 8'hD2, 8'hD3, 0, 1);
        add_px(8'hE1, 8'hE2, 8'hE3, 1, 0);
        drain("sof1");
        check("sof1_n", got_q.size(), 5);
        if (got_q.size() == 5) begin
            check("sof1_pad_word", got_q[2].data, {PAD, PAD, PAD, 8'hC1});
            check("sof1_pad_user", got_q[2].user, 0);
            check("sof1_pad_last", got_q[2].last, 0);
            check("sof1_next_user", got_q[3].user, 1);
        end
        compare("sof1");

        // Backpressure held for 5 cycles
        add_line(8, 0);
        rprob = 100;
        repeat (2) tick();
        rprob = 0;
        repeat (5) tick();
        check("bp_tvalid", bus.out_tvalid, 1);
        check("bp_in_ready", bus.in_ready, 0);
        rprob = 100;
        drain("bp");
        compare("bp");

        // Random traffic: 4 lines of 640, SOF on the first
        for (int l = 0; l < 4; l++) add_line(640, l == 0);
        vprob = 80;
        rprob = 50;
        drain("rand");
        vprob = 100;
        nlast = 0;
        nuser = 0;
        foreach (got_q[i]) begin
            nlast += int'(got_q[i].last);
            nuser += int'(got_q[i].user);
        end
        check("rand_tlast_count", nlast, 4);
        check("rand_tuser_count", nuser, 1);
        compare("rand");

        // Reset mid-line with cnt=2 and a word held
        rprob = 0;
        add_px(8'h51, 8'h52, 8'h53, 0, 0);
        add_px(8'h61, 8'h62, 8'h63, 0, 0);
        repeat (3) tick();
        check("mid_word_held", bus.out_tvalid, 1);
        @(negedge aclk);
        aresetn        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_tready = 1'b0;
        @(negedge aclk);
        #1;
        check("mid_rst_tvalid", bus.out_tvalid, 0);
        aresetn = 1'b1;
        tx_q.delete();
        seg.delete();
        seg_sof   = 1'b0;
        exp_q.delete();
        got_q.delete();
        hold_prev = 1'b0;
        rprob     = 100;
        add_px(8'h11, 8'h12, 8'h13, 0, 0);
        add_px(8'h21, 8'h22, 8'h23, 0, 0);
        add_px(8'h31, 8'h32, 8'h33, 0, 0);
        add_px(8'h41, 8'h42, 8'h43, 1, 0);
        drain("mid");
        check("mid_n", got_q.size(), 3);
        if (got_q.size() > 0) check("mid_w0", got_q[0].data, 32'h23111213);
        compare("mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rgb_stream_packer.md
# rgb_stream_packer

Packs the 24-bit RGB pixel stream from the pixel buffer into a 32-bit AXI4-Stream video stream: four pixels become three words. It preserves line structure with `tlast` and frame structure with `tuser`. It sits directly downstream of the pixel buffer. Its `in_ready` drives the buffer's `in_stream_ready`, and its output feeds the VDMA / AXI4-Stream interconnect.

## Interface
Parameters
- `PAD_BYTE`, default 8'h00: fill value for unused bytes in a flushed, partial word.

Ports
- `aclk`  in  1: the block's only clock.
- `aresetn`  in  1: synchronous, active-low reset, sampled on the `aclk` rising edge.
- `in_r`, `in_g`, `in_b`  in  8 each: pixel colour components.
- `in_valid`  in  1: pixel present. A pixel transfers when `in_valid && in_ready`.
- `in_eol`  in  1: the pixel is the last of its line.
- `in_sof`  in  1: the pixel is the first of its frame.
- `in_ready`  out  1: the block can accept a pixel this cycle.
- `out_tdata`  out  32: packed byte stream.
- `out_tvalid`  out  1: AXI4-Stream valid.
- `out_tready`  in  1: AXI4-Stream ready.
- `out_tlast`  out  1: the word ends a line.
- `out_tuser`  out  1: the word holds the first byte of a frame.

## Operation
- **Byte order.** Each pixel contributes three bytes, in order b, g, r. Bytes fill a word from bits [7:0] upward.
- **Packing example.** For pixels p0..p3: word0 = {b1,r0,g0,b0}, word1 = {g2,b2,r1,g1}, word2 = {r3,g3,b3,r2}.
- **Accumulator.** Holds 0–3 pending bytes in `acc` and a count `cnt` (2 bits).
- **Pixel accept.** When a pixel is accepted, `total = cnt + 3`.
  - `total >= 4`: the low 4 bytes load the output register; `total - 4` bytes stay in `acc`.
  - Otherwise all `total` bytes stay in `acc`.
- **EOL with `in_eol = 1`:**
  - `cnt = 0`: emit 3 bytes padded with `PAD_BYTE`, `tlast = 1`.
  - `cnt = 1`: emit one full word, `tlast = 1`.
  - `cnt = 2` or `cnt = 3`: emit a full word with `tlast = 0`, then enter FLUSH. FLUSH emits the remaining 1 or 2 bytes padded, with `tlast = 1`.
  - In every case, after an EOL `cnt = 0`.
- **SOF with `in_sof = 1` and `cnt != 0`:**
  - Emit the pending bytes as a padded word with `tlast = 0` and `tuser = 0`.
  - The SOF pixel's bytes become the new `acc`, so `cnt = 3`.
  - Bytes from before the SOF are never mixed into a word with bytes of the new frame.
- **`tuser`.** A `sof_pending` flag is set when an SOF pixel is accepted. `tuser` equals `sof_pending` on the next word that contains that pixel's bytes. The flag clears when that word is loaded.
- **States:**
  - RUN → FLUSH: on an EOL accept with `cnt` of 2 or 3.
  - FLUSH → RUN: when the output register is free and the padded remainder word loads.
- **Output register.** A single register. `out_free = !out_tvalid || out_tready`.
- **Ready.** `in_ready = aresetn && state == RUN && out_free`.
  - `in_ready` must not depend on `in_valid`, `in_eol` or `in_sof`. Upstream gates its valid on our ready.

## Timing
- **Reset.** While `aresetn = 0`: `out_tvalid = 0`, `out_tdata = 0`, `out_tlast = 0`, `out_tuser = 0`, `in_ready = 0`, `cnt = 0`, `sof_pending = 0`, state = RUN.
  - The first cycle after release: `in_ready = 1`.
- **Reset mid-operation.** Discards `acc`, any held word and FLUSH. No partial word is emitted.
- **Latency.** The word completed by a pixel accepted on cycle N has `out_tvalid = 1` on cycle N+1.
- **Throughput.** 1 pixel/cycle sustained while `out_tready = 1`. FLUSH costs one `in_ready = 0` cycle after an EOL with `cnt` of 2 or 3.
- **Stability.** While `out_tvalid && !out_tready`: `out_tdata`, `out_tlast` and `out_tuser` hold stable, and `in_ready = 0`.
- **Simultaneous events.** `in_eol && in_sof` on one pixel (a 1-pixel line) applies the SOF flush first, then EOL handling. This can require two words: the first loads now, the second loads via FLUSH.

## Test plan
- **Reset:** hold `aresetn = 0` for 3 cycles with `in_valid = 1`.
  - Required: every output is 0 and no pixel is accepted.
  - Required: cycle 1 after release has `in_ready = 1`.
- **Single packing group:** pixels (r,g,b) = (11,12,13), (21,22,23), (31,32,33), (41,42,43) hex, `eol` on the 4th, `tready = 1`.
  - Required words: 0x23111213, 0x32332122, 0x41424331 with `tlast = 1`.
- **6-pixel line:** `eol` on the 6th pixel.
  - Required: 5 words; the 5th is {16'h0000, r6, g6} with `tlast = 1`.
  - Required: `in_ready = 0` for exactly one cycle after pixel 6.
- **SOF:**
  - SOF on the first pixel: `tuser = 1` on the first word only.
  - SOF arriving with `cnt = 1`: the padded word {PAD, PAD, PAD, byte} has `tuser = 0`, and the next word has `tuser = 1`.
- **Backpressure:**
  - Hold `out_tready = 0` for 5 cycles: outputs stay stable, `in_ready = 0`, no pixel is lost.
  - Random `tready` at 50% over 4 lines of 640 pixels: the byte stream, `tlast` count (4) and `tuser` count (1) match the reference model.
- **Reset mid-line:** assert reset with `cnt = 2` and a word held.
  - Required: no stale word after release.
  - Required: a new line packs from byte 0.
